// File: rtl/glyph_fetch_sched.sv
// Per-line glyph fetch scheduler: shares the greeting and font ROMs among text sprites in hblank.
// Optional code point range check and sticky cp_err output enabled by GLYPH_CP_CHECK_EN.
module glyph_fetch_sched #(
    parameter int unsigned SPR_CNT      = 8,
    parameter int unsigned CORDW        = 10,
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned LINE2        = 240,
    parameter int unsigned GREET_MSGS   = 32,
    parameter int unsigned GREET_LENGTH = 16,
    parameter int unsigned MSG_CHG      = 80,
    parameter int unsigned CP_START     = 'h20,
    parameter int unsigned CP_END       = 'h5F,
    parameter int unsigned FONT_HEIGHT  = 8,
    parameter int unsigned ROM_LAT      = 1,
    localparam int unsigned GAW = $clog2(GREET_MSGS * GREET_LENGTH),
    localparam int unsigned FAW = $clog2((CP_END - CP_START + 1) * FONT_HEIGHT),
    localparam int unsigned LW  = $clog2(FONT_HEIGHT),
    localparam int unsigned MW  = $clog2(GREET_MSGS)
) (
    input  logic                  clk_pix,
    input  logic                  rst_n,
    input  logic [CORDW-1:0]      sx,
    input  logic [CORDW-1:0]      sy,
    output logic [GAW-1:0]        greet_addr,
    input  logic [6:0]            greet_data,
    output logic [FAW-1:0]        font_addr,
    input  logic [SPR_CNT*LW-1:0] spr_line,
    output logic [SPR_CNT-1:0]    dma_avail,
    output logic [MW-1:0]         greeting,
    output logic                  busy
`ifdef GLYPH_CP_CHECK_EN
    ,
    output logic                  cp_err
`endif
);

    localparam int unsigned STEPS = SPR_CNT + ROM_LAT + 1;
    localparam int unsigned TW    = $clog2(STEPS + 1);
    localparam int unsigned FCW   = (MSG_CHG > 1) ? $clog2(MSG_CHG) : 1;
    localparam int unsigned KW    = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t           state;
    logic [TW-1:0]    step;
    logic [GAW-1:0]   msg_base;
    logic [FCW-1:0]   frame_cnt;
    logic [6:0]       cp     [SPR_CNT];
    logic [6:0]       cp_nxt [SPR_CNT];
    logic [LW-1:0]    line_arr [SPR_CNT];

    logic             line_start;
    logic             frame_tick;
    logic [GAW-1:0]   base_new;
    logic [GAW-1:0]   base_cur;
    logic [TW-1:0]    t_cur;
    logic             addr_slot;
    logic             gnt;
    logic [KW-1:0]    k;
    logic [6:0]       cp_in;
    logic             cp_bad;
    logic [6:0]       cp_sel;
    logic [FAW-1:0]   font_nxt;

    for (genvar i = 0; i < SPR_CNT; i++) begin : g_line
        assign line_arr[i] = spr_line[i*LW +: LW];
    end

    // Slot decode: t counts from the FETCH entry edge; address at t=k, grant at t=k+ROM_LAT+1
    always_comb begin
        line_start = (sx == CORDW'(H_RES));
        frame_tick = line_start && (sy == CORDW'(V_RES));
        base_new   = GAW'(greeting) * GAW'(GREET_LENGTH)
                   + ((sy >= CORDW'(LINE2)) ? GAW'(GREET_LENGTH / 2) : '0);
        base_cur   = (state == FETCH) ? msg_base : base_new;
        t_cur      = (state == FETCH) ? step : '0;
        addr_slot  = ((state == FETCH) || ((state == IDLE) && line_start))
                   && (t_cur < TW'(SPR_CNT));
        gnt        = (state == FETCH) && (step >= TW'(ROM_LAT + 1))
                   && (step <= TW'(SPR_CNT + ROM_LAT));
        k          = KW'(step - TW'(ROM_LAT + 1));
`ifdef GLYPH_CP_CHECK_EN
        cp_bad     = (greet_data < 7'(CP_START)) || (greet_data > 7'(CP_END));
        cp_in      = cp_bad ? 7'(CP_START) : greet_data;
`else
        cp_bad     = 1'b0;
        cp_in      = greet_data;
`endif
        cp_nxt     = cp;
        if (gnt) begin
            cp_nxt[k] = cp_in;
        end
        cp_sel     = cp_nxt[k];
        font_nxt   = FAW'((FAW'(cp_sel) - FAW'(CP_START)) * FAW'(FONT_HEIGHT)
                   + FAW'(line_arr[k]));
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            msg_base   <= '0;
            frame_cnt  <= '0;
            greeting   <= '0;
            cp         <= '{default: '0};
            greet_addr <= '0;
            font_addr  <= '0;
            dma_avail  <= '0;
            busy       <= 1'b0;
`ifdef GLYPH_CP_CHECK_EN
            cp_err     <= 1'b0;
`endif
        end else begin
            greet_addr <= addr_slot ? GAW'(base_cur + GAW'(t_cur)) : '0;
            dma_avail  <= gnt ? (SPR_CNT'(1) << k) : '0;
            font_addr  <= gnt ? font_nxt : '0;
            cp         <= cp_nxt;
`ifdef GLYPH_CP_CHECK_EN
            if (gnt && cp_bad) begin
                cp_err <= 1'b1;
            end
`endif

            // Message rotation; the tick shares its edge with FETCH entry on line V_RES
            if (frame_tick) begin
                if (frame_cnt == FCW'(MSG_CHG - 1)) begin
                    frame_cnt <= '0;
                    greeting  <= (greeting == MW'(GREET_MSGS - 1)) ? '0 : MW'(greeting + 1'b1);
                end else begin
                    frame_cnt <= FCW'(frame_cnt + 1'b1);
                end
            end

            case (state)
                IDLE: begin
                    if (line_start) begin
                        state    <= FETCH;
                        step     <= TW'(1);
                        msg_base <= base_new;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (step == TW'(STEPS)) begin
                        state <= DONE;
                    end else begin
                        step <= TW'(step + 1'b1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Directed bench for glyph_fetch_sched with a one-cycle-latency greeting ROM model.
// Also covers cp_err when built with GLYPH_CP_CHECK_EN.
module tb_glyph_fetch_sched;

    localparam int unsigned SPR_CNT = 8;
    localparam int unsigned CORDW   = 10;
    localparam int unsigned LW      = 3;

    logic                  clk_pix = 1'b0;
    logic                  rst_n;
    logic [CORDW-1:0]      sx;
    logic [CORDW-1:0]      sy;
    logic [8:0]            greet_addr;
    logic [6:0]            greet_data;
    logic [8:0]            font_addr;
    logic [SPR_CNT*LW-1:0] spr_line;
    logic [SPR_CNT-1:0]    dma_avail;
    logic [4:0]            greeting;
    logic                  busy;
`ifdef GLYPH_CP_CHECK_EN
    logic                  cp_err;
`endif

    logic [6:0] rom [512];
    int         fexp [SPR_CNT];
    int         vectors = 0;
    int         errors  = 0;

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) greet_data <= rom[greet_addr];

    glyph_fetch_sched dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .sx         (sx),
        .sy         (sy),
        .greet_addr (greet_addr),
        .greet_data (greet_data),
        .font_addr  (font_addr),
        .spr_line   (spr_line),
        .dma_avail  (dma_avail),
        .greeting   (greeting),
        .busy       (busy)
`ifdef GLYPH_CP_CHECK_EN
        ,
        .cp_err     (cp_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle at negedge, then sample 1 ns after the rising edge
    task automatic cyc(input int x, input int y);
        @(negedge clk_pix);
        sx = CORDW'(x);
        sy = CORDW'(y);
        @(posedge clk_pix);
        #1;
    endtask

    // Sweep one hblank: addresses at 640..647, grants at 642..649, busy through 650
    task automatic run_line(input int y, input int base, input bit chk_font);
        for (int s = 636; s < 656; s++) begin
            cyc(s, y);
            chk("greet_addr", 32'(greet_addr), (s >= 640 && s < 648) ? 32'(base + s - 640) : 32'd0);
            chk("dma_avail", 32'(dma_avail), (s >= 642 && s < 650) ? (32'd1 << (s - 642)) : 32'd0);
            chk("busy", 32'(busy), (s >= 640 && s <= 650) ? 32'd1 : 32'd0);
            if (chk_font) begin
                chk("font_addr", 32'(font_addr), (s >= 642 && s < 650) ? 32'(fexp[s - 642]) : 32'd0);
            end
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) cyc(0, 0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 7'('h20 + (i % 64));
        rom[0] = 7'h48; rom[1] = 7'h45; rom[2] = 7'h4C; rom[3] = 7'h4C;
        rom[4] = 7'h4F; rom[5] = 7'h20; rom[6] = 7'h57; rom[7] = 7'h21;
        for (int i = 0; i < 8; i++) rom[8 + i] = 7'(7'h41 + i);
        spr_line = {SPR_CNT{3'd3}};
        rst_n = 1'b0;
        sx = '0;
        sy = '0;

        // Reset state
        cyc(0, 0);
        cyc(0, 0);
        chk("rst_greet_addr", 32'(greet_addr), 0);
        chk("rst_font_addr", 32'(font_addr), 0);
        chk("rst_dma", 32'(dma_avail), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_greeting", 32'(greeting), 0);
`ifdef GLYPH_CP_CHECK_EN
        chk("rst_cp_err", 32'(cp_err), 0);
`endif
        rst_n = 1'b1;
        cyc(0, 0);

        // "HELLO W!" on line 10, glyph line 3
        fexp = '{323, 299, 355, 355, 379, 3, 443, 11};
        run_line(10, 0, 1'b1);

        // Second half of message 0 on line 300, glyph line k for sprite k
        for (int i = 0; i < SPR_CNT; i++) spr_line[i*LW +: LW] = 3'(i);
        for (int i = 0; i < SPR_CNT; i++) fexp[i] = 264 + 9 * i;
        run_line(300, 8, 1'b1);
        spr_line = {SPR_CNT{3'd3}};

        // 80 frame ticks advance the message exactly once
        for (int i = 0; i < 79; i++) cyc(640, 480);
        chk("greeting_79", 32'(greeting), 0);
        cyc(640, 480);
        chk("greeting_80", 32'(greeting), 1);

        // Bring greeting to 5 with frame_cnt at 79
        for (int i = 0; i < 399; i++) cyc(640, 480);
        settle();
        chk("greeting_5", 32'(greeting), 5);

        // Coincident tick: base uses greeting 5 (second half, sy >= 240) -> 88, then 6 -> 104
        run_line(480, 88, 1'b0);
        chk("greeting_6", 32'(greeting), 6);
        run_line(481, 104, 1'b0);

        // Reset asserted at sx 644 aborts the sequence
        for (int s = 636; s < 656; s++) begin
            @(negedge clk_pix);
            sx = CORDW'(s);
            sy = CORDW'(10);
            rst_n = (s == 644) ? 1'b0 : 1'b1;
            @(posedge clk_pix);
            #1;
            if (s == 644) begin
                chk("midrst_busy", 32'(busy), 0);
                chk("midrst_greeting", 32'(greeting), 0);
                chk("midrst_dma", 32'(dma_avail), 0);
            end else if (s > 644) begin
                chk("post_rst_dma", 32'(dma_avail), 0);
                chk("post_rst_greet_addr", 32'(greet_addr), 0);
                chk("post_rst_busy", 32'(busy), 0);
            end
        end
        rst_n = 1'b1;
        fexp = '{323, 299, 355, 355, 379, 3, 443, 11};
        run_line(10, 0, 1'b1);

        // Full wrap of the message index
        for (int i = 0; i < 32 * 80 - 1; i++) cyc(640, 480);
        chk("greeting_31", 32'(greeting), 31);
        cyc(640, 480);
        chk("greeting_wrap", 32'(greeting), 0);
        settle();

        // Out-of-range code point 'z' for sprite 2
        rom[2] = 7'h7A;
`ifdef GLYPH_CP_CHECK_EN
        chk("cp_err_before", 32'(cp_err), 0);
        fexp = '{323, 299, 3, 355, 379, 3, 443, 11};
`else
        fexp = '{323, 299, 211, 355, 379, 3, 443, 11};
`endif
        run_line(10, 0, 1'b1);
`ifdef GLYPH_CP_CHECK_EN
        chk("cp_err_set", 32'(cp_err), 1);
        rom[2] = 7'h4C;
        run_line(10, 0, 1'b0);
        chk("cp_err_sticky", 32'(cp_err), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
